// File: rtl/top_burst_scheduler_pkg.sv
// Shared types and constants for the burst scheduler and its outstanding tracker.
package top_burst_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } burst_sched_state_t;

    localparam int LP_4K_BYTES  = 4096;
    localparam int LP_MAX_ARLEN = 255;

    // log2 of the bytes carried by one data beat (data width is a power-of-two number of bytes)
    function automatic int beat_shift(input int data_width);
        int bytes;
        int shift;
        bytes = data_width / 8;
        shift = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) == bytes) begin
                shift = i;
            end
        end
        return shift;
    endfunction

endpackage

// File: rtl/top_outstanding_tracker.sv
// Up/down counter of issued-but-incomplete bursts. A completion with nothing in
// flight is dropped so the count never wraps below zero.
module top_outstanding_tracker
    import top_burst_scheduler_pkg::*;
#(
    parameter int C_MAX_OUTSTANDING = 16,
    parameter int C_CNT_WIDTH       = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   incr,
    input  logic                   decr,
    output logic [C_CNT_WIDTH-1:0] count,
    output logic                   is_zero,
    output logic                   is_full
);

    logic decr_eff;

    assign is_zero  = (count == '0);
    assign is_full  = (count == C_CNT_WIDTH'(C_MAX_OUTSTANDING));
    assign decr_eff = decr && !is_zero;

    // Count moves only when exactly one of issue/completion happens this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (incr && !decr_eff && !is_full) begin
            count <= count + C_CNT_WIDTH'(1);
        end else if (decr_eff && !incr) begin
            count <= count - C_CNT_WIDTH'(1);
        end
    end

`ifndef SYNTHESIS
    // A burst completion with no burst in flight points at a broken data path
    assert property (@(posedge clk) disable iff (rst) !(decr && is_zero));
`endif

endmodule

// File: rtl/top_burst_scheduler.sv
// Read-request scheduler: splits (offset, byte count) commands into read-address
// bursts, bounds bursts in flight and pulses ctrl_done once all have returned.
// Optional macro TOP_BURST_SCHED_4K_SPLIT_EN additionally cuts bursts at 4 KiB
// boundaries; without it the caller guarantees boundary safety.
//
// state    | meaning
// ST_IDLE  | waiting for ctrl_start
// ST_ISSUE | issuing bursts until no beats remain
// ST_DRAIN | all bursts issued, waiting for outstanding to reach zero
module top_burst_scheduler
    import top_burst_scheduler_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_MAX_BURST_LEN   = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [C_ADDR_WIDTH-1:0]      araddr,
    output logic [7:0]                   arlen,
    input  logic                         burst_done
);

    localparam int BEAT_SHIFT = beat_shift(C_DATA_WIDTH);
    localparam int BURST_CAP  = (C_MAX_BURST_LEN > LP_MAX_ARLEN + 1) ? (LP_MAX_ARLEN + 1) : C_MAX_BURST_LEN;
    localparam int CNT_WIDTH  = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] BEAT_MASK = C_XFER_SIZE_WIDTH'((1 << BEAT_SHIFT) - 1);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] CAP_BEATS = C_XFER_SIZE_WIDTH'(BURST_CAP);
    localparam logic [CNT_WIDTH-1:0]         LAST_SLOT = CNT_WIDTH'(C_MAX_OUTSTANDING - 1);

    burst_sched_state_t state;

    logic [C_ADDR_WIDTH-1:0]      addr_q;
    logic [C_ADDR_WIDTH-1:0]      src_addr;
    logic [C_XFER_SIZE_WIDTH-1:0] rem_q;
    logic [C_XFER_SIZE_WIDTH-1:0] src_rem;
    logic [C_XFER_SIZE_WIDTH-1:0] start_beats;
    logic [C_XFER_SIZE_WIDTH-1:0] next_beats;
    logic [7:0]                   next_arlen;
    logic [8:0]                   cur_beats;
    logic                         hs;
    logic                         full_after_hs;
    logic [CNT_WIDTH-1:0]         out_count;
    logic                         out_zero;
    logic                         out_full;
`ifdef TOP_BURST_SCHED_4K_SPLIT_EN
    logic [12:0]                  page_bytes;
    logic [C_XFER_SIZE_WIDTH-1:0] page_beats;
`endif

    assign hs          = arvalid && arready;
    assign cur_beats   = {1'b0, arlen} + 9'd1;
    assign start_beats = (ctrl_xfer_size_in_bytes >> BEAT_SHIFT)
                       + C_XFER_SIZE_WIDTH'((ctrl_xfer_size_in_bytes & BEAT_MASK) != '0);
    // The request being accepted fills the last slot unless a completion frees one in the same cycle
    assign full_after_hs = !(burst_done && !out_zero) && (out_count == LAST_SLOT);

    top_outstanding_tracker #(
        .C_MAX_OUTSTANDING (C_MAX_OUTSTANDING),
        .C_CNT_WIDTH       (CNT_WIDTH)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .incr    (hs),
        .decr    (burst_done),
        .count   (out_count),
        .is_zero (out_zero),
        .is_full (out_full)
    );

    // Address/remaining the next request is built from, and that request's size
    always_comb begin
        src_addr = addr_q;
        src_rem  = rem_q;
        if (state == ST_IDLE) begin
            src_addr = ctrl_addr_offset;
            src_rem  = start_beats;
        end else if (hs) begin
            src_addr = addr_q + (C_ADDR_WIDTH'(cur_beats) << BEAT_SHIFT);
            src_rem  = rem_q - C_XFER_SIZE_WIDTH'(cur_beats);
        end
        next_beats = (src_rem < CAP_BEATS) ? src_rem : CAP_BEATS;
`ifdef TOP_BURST_SCHED_4K_SPLIT_EN
        page_bytes = 13'(LP_4K_BYTES) - {1'b0, src_addr[11:0]};
        page_beats = C_XFER_SIZE_WIDTH'(page_bytes >> BEAT_SHIFT);
        if (page_beats < next_beats) begin
            next_beats = page_beats;
        end
`endif
        next_arlen = next_beats[7:0] - 8'd1;
    end

    // Sequencing FSM with registered request and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            ctrl_busy <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        addr_q    <= src_addr;
                        rem_q     <= src_rem;
                        ctrl_busy <= 1'b1;
                        if (src_rem == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state   <= ST_ISSUE;
                            arvalid <= 1'b1;
                            araddr  <= src_addr;
                            arlen   <= next_arlen;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        addr_q <= src_addr;
                        rem_q  <= src_rem;
                        araddr <= src_addr;
                        arlen  <= next_arlen;
                        if (src_rem == '0) begin
                            arvalid <= 1'b0;
                            state   <= ST_DRAIN;
                        end else begin
                            arvalid <= !full_after_hs;
                        end
                    end else if (!arvalid && !out_full) begin
                        arvalid <= 1'b1;
                        araddr  <= src_addr;
                        arlen   <= next_arlen;
                    end
                end
                ST_DRAIN: begin
                    if (out_zero) begin
                        ctrl_done <= 1'b1;
                        ctrl_busy <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_burst_scheduler.sv
// Scoreboard bench for top_burst_scheduler: commands push expected bursts into a
// queue from a byte-level split model; a monitor pops and compares on each handshake.
module tb_top_burst_scheduler;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XS = 32;
    localparam int MBL = 64;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctrl_start = 1'b0;
    logic [AW-1:0] ctrl_addr_offset = '0;
    logic [XS-1:0] ctrl_xfer_size_in_bytes = '0;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          burst_done = 1'b0;

    top_burst_scheduler #(
        .C_ADDR_WIDTH      (AW),
        .C_DATA_WIDTH      (DW),
        .C_XFER_SIZE_WIDTH (XS),
        .C_MAX_BURST_LEN   (MBL),
        .C_MAX_OUTSTANDING (MO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ctrl_start              (ctrl_start),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_busy               (ctrl_busy),
        .ctrl_done               (ctrl_done),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .burst_done              (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t exp_q[$];
    int   exp_done[$];
    int   due_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_out = 0;
    int n_done = 0;
    int n_hs = 0;
    int ar_mode = 1;      // 0 random, 1 always ready, 2 never ready
    bit hold_done = 1'b0;
    int release_cnt = 0;
    int bd_min = 1;
    int bd_max = 12;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=none (cycle %0d)", name, act, cyc);
    endtask

    // Byte-level reference: walk the transfer beat by beat-group
    function automatic void model_cmd(input logic [63:0] addr, input logic [31:0] size);
        longint unsigned beats;
        longint unsigned n;
        longint unsigned pg;
        logic [63:0]     a;
        req_t            r;
        beats = (longint'(size) + 63) / 64;
        a = addr;
        while (beats > 0) begin
            n = (beats > 64) ? 64 : beats;
`ifdef TOP_BURST_SCHED_4K_SPLIT_EN
            pg = (4096 - (a % 4096)) / 64;
            if (pg < n) n = pg;
`else
            pg = 0;
`endif
            r.addr = a;
            r.len = 8'(n - 1);
            exp_q.push_back(r);
            a = a + n * 64;
            beats = beats - n;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder: drives arready and burst_done for due completions
    initial forever begin
        @(posedge clk);
        #1;
        arready = (ar_mode == 0) ? ($urandom_range(0, 3) != 0) : (ar_mode == 1);
        burst_done = 1'b0;
        if (!hold_done || release_cnt > 0) begin
            for (int i = 0; i < due_q.size(); i++) begin
                if (due_q[i] <= cyc) begin
                    due_q.delete(i);
                    burst_done = 1'b1;
                    if (hold_done) release_cnt--;
                    break;
                end
            end
        end
    end

    // Monitor: pops expectations when the DUT presents requests or completion
    initial begin
        bit          pv = 1'b0;
        bit          pr = 1'b0;
        logic [63:0] pa = '0;
        logic [7:0]  pl = '0;
        req_t        r;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                model_out = 0;
                exp_q.delete();
                exp_done.delete();
                due_q.delete();
            end else begin
                if (pv && !pr) begin
                    chk("hold_arvalid", arvalid, 1);
                    chk("hold_araddr", araddr, pa);
                    chk("hold_arlen", arlen, pl);
                end
                if (arvalid && !pv) chk("outstanding_gate", (model_out < MO), 1);
                if (arvalid && arready) begin
                    n_hs++;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_request", araddr);
                    end else begin
                        r = exp_q.pop_front();
                        chk("araddr", araddr, r.addr);
                        chk("arlen", arlen, r.len);
                    end
                    model_out++;
                    due_q.push_back(cyc + $urandom_range(bd_min, bd_max));
                end
                if (burst_done) begin
                    model_out--;
                    if (model_out == 0 && exp_q.size() == 0) exp_done.push_back(cyc + 2);
                end
                if (exp_done.size() > 0 && cyc > exp_done[0]) begin
                    fail("missed_done", exp_done.pop_front());
                end
                if (ctrl_done) begin
                    n_done++;
                    chk("busy_at_done", ctrl_busy, 0);
                    if (exp_done.size() == 0) fail("unexpected_done", cyc);
                    else chk("done_cycle", cyc, exp_done.pop_front());
                end
                pv = arvalid;
                pr = arready;
                pa = araddr;
                pl = arlen;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int start_n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (n_done > start_n) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) fail("done_timeout", n_done);
        chk("idle_after_done", ctrl_busy, 0);
    endtask

    task automatic run_cmd(input logic [63:0] addr, input logic [31:0] size, input bit wait_for_done);
        int start_n;
        start_n = n_done;
        model_cmd(addr, size);
        ctrl_addr_offset = addr;
        ctrl_xfer_size_in_bytes = size;
        ctrl_start = 1'b1;
        if (size == 0) exp_done.push_back(cyc + 2);
        tick(1);
        ctrl_start = 1'b0;
        ctrl_addr_offset = $urandom();
        ctrl_xfer_size_in_bytes = $urandom();
        chk("busy_after_start", ctrl_busy, 1);
        chk("arvalid_after_start", arvalid, (size != 0));
        if (wait_for_done) wait_done(start_n);
    endtask

    initial begin
        int          h0;
        int          d0;
        logic [63:0] sa;
        logic [7:0]  sl;
        logic [63:0] ra;
        logic [11:0] lo;
        logic [31:0] rs;

        rst = 1'b1;
        tick(3);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        rst = 1'b0;
        tick(2);

        // zero-size, 8 KiB with fixed 10-cycle completions, short, boundary-straddling
        run_cmd(64'h0, 32'd0, 1'b1);
        bd_min = 10;
        bd_max = 10;
        run_cmd(64'h0, 32'd8192, 1'b1);
        run_cmd(64'h4000, 32'd100, 1'b1);
        run_cmd(64'hFC0, 32'd256, 1'b1);
        bd_min = 1;
        bd_max = 12;

        // outstanding limit with completions withheld, then one released
        hold_done = 1'b1;
        h0 = n_hs;
        d0 = n_done;
        run_cmd(64'h0, 32'd65536, 1'b0);
        tick(20);
        chk("hs_at_limit", n_hs - h0, 4);
        chk("arvalid_at_limit", arvalid, 0);
        release_cnt = 1;
        tick(10);
        chk("hs_after_release", n_hs - h0, 5);
        chk("arvalid_after_release", arvalid, 0);
        hold_done = 1'b0;
        release_cnt = 0;
        wait_done(d0);

        // stalled request then reset mid-operation
        ar_mode = 2;
        run_cmd(64'h2000, 32'd4096, 1'b0);
        sa = araddr;
        sl = arlen;
        tick(5);
        chk("stall_arvalid", arvalid, 1);
        chk("stall_araddr", araddr, sa);
        chk("stall_arlen", arlen, sl);
        d0 = n_done;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_arvalid", arvalid, 0);
        chk("midrst_busy", ctrl_busy, 0);
        ar_mode = 0;
        tick(6);
        chk("no_done_after_rst", n_done, d0);

        // randomized commands under random backpressure and completion latency
        bd_min = 1;
        bd_max = 15;
        for (int k = 0; k < 25; k++) begin
            ra = {$urandom(), $urandom()} & ~64'h3F;
            if ($urandom_range(0, 1) == 1) begin
                lo = 12'(4096 - 64 * $urandom_range(1, 8));
                ra[11:0] = lo;
            end
            case ($urandom_range(0, 3))
                0: rs = $urandom_range(0, 200);
                1: rs = $urandom_range(1, 20000);
                2: rs = 32'(4096 * $urandom_range(1, 4));
                default: rs = 32'd0;
            endcase
            run_cmd(ra, rs, 1'b1);
            tick($urandom_range(0, 2));
        end

        tick(5);
        chk("leftover_requests", exp_q.size(), 0);
        chk("leftover_dones", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=cycle%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/top_burst_scheduler.md
# top_burst_scheduler

Read-request scheduler for the kernel's memory-mapped master path. It takes a transfer command (start offset, byte count) from the control block and splits it into AXI-style address requests of at most `C_MAX_BURST_LEN` beats. It bounds in-flight bursts to `C_MAX_OUTSTANDING` with an up/down outstanding counter, and pulses `ctrl_done` once every issued burst has returned. It sits between the control/register block and the AXI read-address channel, one instance per input stream.

## Interface
- `C_ADDR_WIDTH`, 64: address width.
- `C_DATA_WIDTH`, 512: data bus width in bits; bytes per beat = `C_DATA_WIDTH/8`.
- `C_XFER_SIZE_WIDTH`, 32: byte-count width.
- `C_MAX_BURST_LEN`, 64: max beats per burst (1..256).
- `C_MAX_OUTSTANDING`, 16: max issued-but-incomplete bursts (≥1).
- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous and active-high.
- `ctrl_start` input 1: one-cycle start pulse; sampled only in IDLE.
- `ctrl_addr_offset` input C_ADDR_WIDTH: start address, beat-aligned; sampled with `ctrl_start`.
- `ctrl_xfer_size_in_bytes` input C_XFER_SIZE_WIDTH: transfer size; sampled with `ctrl_start`.
- `ctrl_busy` output 1: high while state ≠ IDLE.
- `ctrl_done` output 1: one-cycle completion pulse.
- `arvalid` output 1: request valid.
- `arready` input 1: request accepted.
- `araddr` output C_ADDR_WIDTH: burst start address.
- `arlen` output 8: beats-1.
- `burst_done` input 1: one-cycle pulse per completed burst (the data path's rvalid & rready & rlast).

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE, `ctrl_start`=1:
  - Latch address.
  - Compute remaining beats = ceil(size / bytes_per_beat).
  - If remaining = 0, go to DRAIN; otherwise go to ISSUE.
- ISSUE:
  - `arvalid`=1 whenever outstanding < `C_MAX_OUTSTANDING`.
  - Burst beats = min(remaining, `C_MAX_BURST_LEN`), further limited by the `_EN` feature.
  - `arlen` = beats-1.
- Handshake (`arvalid & arready`):
  - Address += beats × bytes_per_beat.
  - Remaining -= beats.
  - Outstanding +1.
  - If the new remaining = 0, go to DRAIN.
- `burst_done`: outstanding −1.
  - Simultaneous handshake and `burst_done`: outstanding unchanged.
  - `burst_done` with outstanding = 0 is ignored (no underflow); the simulation assertion flags it.
- DRAIN, registered outstanding = 0: register `ctrl_done`=1 and go to IDLE.
- `ctrl_start` outside IDLE is ignored.
- Once asserted, `arvalid` is held with `araddr`/`arlen` stable until `arready`. The outstanding limit only gates a new assertion.
- Arithmetic: remaining in beats, width `C_XFER_SIZE_WIDTH`. Address adds wrap modulo 2^C_ADDR_WIDTH.
- Reset values: state IDLE, `ctrl_busy`=0, `ctrl_done`=0, `arvalid`=0, `araddr`=0, `arlen`=0, outstanding=0, remaining=0.
- Reset mid-operation: everything returns to reset values next cycle, with no `ctrl_done`. Late `burst_done` pulses are ignored.

## Timing
- `ctrl_start` at cycle T: `ctrl_busy` and first `arvalid` at T+1.
- Zero size: `ctrl_done` at T+2, no requests.
- After a handshake at cycle H, the next request is valid at H+1 at the earliest, giving back-to-back bursts at full rate.
- Last `burst_done` at cycle N (outstanding → 0 at N+1): `ctrl_done`=1 and `ctrl_busy`=0 at N+2.
- Earliest new `ctrl_start` accepted: N+2.

## Configuration
- `TOP_BURST_SCHED_4K_SPLIT_EN` defined:
  - Burst beats are additionally limited to (4096 − (addr mod 4096)) / bytes_per_beat.
  - No burst crosses a 4 KiB boundary.
- Macro undefined:
  - Bursts are limited only by remaining and `C_MAX_BURST_LEN`.
  - The caller guarantees boundary safety.

## Structure
- Package `top_burst_scheduler_pkg` holds:
  - State enum `burst_sched_state_t`.
  - `LP_4K_BYTES` = 4096.
  - `LP_MAX_ARLEN` = 255.
  - Function computing log2(bytes_per_beat).
- Sub-module `top_outstanding_tracker`:
  - Parameterised up/down counter with incr/decr, saturating at 0.
  - Outputs `is_zero` and `is_full` (count = `C_MAX_OUTSTANDING`).

## Test plan
All scenarios use `C_DATA_WIDTH`=512 (64 B/beat) and `C_MAX_BURST_LEN`=64.
- Size 0, `ctrl_start` at T → no `arvalid`; `ctrl_done` one cycle at T+2.
- Addr 0x0, size 8192, `arready`=1, `burst_done` 10 cycles after each handshake → requests (0x0, arlen 63) then (0x1000, arlen 63); `ctrl_done` 2 cycles after the second `burst_done`.
- Size 100 → one request with arlen 1; `ctrl_done` after one `burst_done`.
- `C_MAX_OUTSTANDING`=4, size 65536, no `burst_done` → exactly 4 handshakes, then `arvalid`=0. One `burst_done` pulse → exactly one more request.
- `arready`=0 for 5 cycles → `arvalid`, `araddr`, `arlen` stable. `rst` pulse mid-stall → next cycle `arvalid`=0, `ctrl_busy`=0, no `ctrl_done`.
- Addr 0xFC0, size 256 → with `_EN`: (0xFC0, arlen 0) then (0x1000, arlen 2). Without `_EN`: single (0xFC0, arlen 3).
